// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write path.
// Address/data widths, the zero register and the requester enum.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a hold-off input for requester A.
// Owns the priority flop; each ready depends only on the other side's valid.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic aValid,
    input  logic bValid,
    input  logic aStall,
    output logic aReady,
    output logic bReady,
    output logic aGrant,
    output logic bGrant
);

    req_e prio;
    req_e prioNext;

    always_comb begin
        aReady   = !rst && !aStall && !(bValid && prio == REQ_B);
        bReady   = !rst && !(aValid && prio == REQ_A && !aStall);
        aGrant   = aValid && aReady;
        bGrant   = bValid && bReady;
        prioNext = prio;
        unique case (1'b1)
            aGrant:  prioNext = REQ_B;
            bGrant:  prioNext = REQ_A;
            default: prioNext = prio;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ_A;
        end else begin
            prio <= prioNext;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU (A) and multi-cycle (B)
// writeback, with a reservation scoreboard for B's outstanding destinations.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic                aStall;
    logic                aGrant;
    logic                bGrant;
    logic                rsvAccept;
    logic [NUM_REGS-1:0] busyQ;
    logic [NUM_REGS-1:0] setMask;
    logic [NUM_REGS-1:0] clrMask;
    logic [ADDR_W-1:0]   winAddr;
    logic [DATA_W-1:0]   winData;

    // WAW: A may not overtake a pending B write to the same register
    assign aStall = busyQ[a_addr] && (a_addr != REG_ZERO);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .aValid (a_valid),
        .bValid (b_valid),
        .aStall (aStall),
        .aReady (a_ready),
        .bReady (b_ready),
        .aGrant (aGrant),
        .bGrant (bGrant)
    );

    assign rsv_ready = !rst && !busyQ[rsv_addr];
    assign rsvAccept = rsv_valid && rsv_ready;

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (rsvAccept && rsv_addr != REG_ZERO) begin
            setMask = NUM_REGS'(1) << rsv_addr;
        end
        if (bGrant) begin
            clrMask = NUM_REGS'(1) << b_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busyQ <= '0;
        end else begin
            busyQ <= (busyQ & ~clrMask) | setMask;
        end
    end

    assign busy_vec = busyQ;

    always_comb begin
        winAddr = a_addr;
        winData = a_data;
        if (bGrant) begin
            winAddr = b_addr;
            winData = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (aGrant || bGrant) begin
            rf_we    <= (winAddr != REG_ZERO);
            rf_waddr <= winAddr;
            rf_wdata <= winData;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // the commit-cycle write is not yet visible to the async read
    assign rd_busy1 = (rd_addr1 != REG_ZERO) &&
                      (busyQ[rd_addr1] || (rf_we && rf_waddr == rd_addr1));
    assign rd_busy2 = (rd_addr2 != REG_ZERO) &&
                      (busyQ[rd_addr2] || (rf_we && rf_waddr == rd_addr2));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed plan plus random traffic.
// A behavioural model predicts readies, hazards and the register file writes.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        rsv_ready;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        rd_busy1;
    logic        rd_busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy_vec  (busy_vec)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int   nCmp = 0;
    int   nBad = 0;
    wr_t  expQ[$];

    // reference model state
    bit          busyM[32];
    bit          turnB;
    bit          pendWe;
    logic [4:0]  pendAddr;
    logic [4:0]  expWaddr;
    logic [31:0] expWdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = nobody written, 1 = A, 2 = B
    function automatic int pick(bit av, bit stalled, bit bv, bit r);
        if (r) return 0;
        if (av && !stalled && bv) return turnB ? 2 : 1;
        if (av && !stalled) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    function automatic bit hazard(logic [4:0] rd);
        if (rd == 5'd0) return 1'b0;
        return busyM[rd] || (pendWe && pendAddr == rd);
    endfunction

    task automatic step(
        input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
        input bit bv, input logic [4:0] ba, input logic [31:0] bd,
        input bit rv, input logic [4:0] ra,
        input logic [4:0] r1, input logic [4:0] r2
    );
        bit          stalled;
        bit          expRr;
        int          w;
        logic [31:0] bvec;
        @(negedge clk);
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rsv_valid = rv; rsv_addr = ra; rd_addr1 = r1; rd_addr2 = r2;
        #1;
        stalled = busyM[aa] && aa != 5'd0;
        expRr   = !r && !busyM[ra];
        w       = pick(av, stalled, bv, r);
        for (int i = 0; i < 32; i++) bvec[i] = busyM[i];
        chk("a_ready", 32'(a_ready), 32'(pick(1'b1, stalled, bv, r) == 1));
        chk("b_ready", 32'(b_ready), 32'(pick(av, stalled, 1'b1, r) == 2));
        chk("rsv_ready", 32'(rsv_ready), 32'(expRr));
        chk("rd_busy1", 32'(rd_busy1), 32'(hazard(r1)));
        chk("rd_busy2", 32'(rd_busy2), 32'(hazard(r2)));
        chk("busy_vec", busy_vec, bvec);
        chk("rf_we", 32'(rf_we), 32'(pendWe));
        chk("rf_waddr", 32'(rf_waddr), 32'(expWaddr));
        chk("rf_wdata", rf_wdata, expWdata);
        if (r) begin
            busyM = '{default: 1'b0};
            turnB = 1'b0; pendWe = 1'b0; pendAddr = '0;
            expWaddr = '0; expWdata = '0;
        end else begin
            pendWe = 1'b0;
            if (w == 1) begin
                expWaddr = aa; expWdata = ad; turnB = 1'b1;
            end
            if (w == 2) begin
                expWaddr = ba; expWdata = bd; turnB = 1'b0;
                busyM[ba] = 1'b0;
            end
            if (w != 0) begin
                pendWe = expWaddr != 5'd0;
                pendAddr = expWaddr;
            end
            if (rv && expRr && ra != 5'd0) busyM[ra] = 1'b1;
            if (pendWe) expQ.push_back('{addr: expWaddr, data: expWdata});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: every committed write must match the next expected one
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rf_we === 1'b1) begin
                if (expQ.size() == 0) begin
                    nCmp++;
                    nBad++;
                    $display("FAIL rf_commit: unexpected write addr %0d data %0h", rf_waddr, rf_wdata);
                end else begin
                    e = expQ.pop_front();
                    chk("commit_addr", 32'(rf_waddr), 32'(e.addr));
                    chk("commit_data", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        bit          r, av, bv, rv;
        logic [4:0]  aa, ba, ra;
        busyM = '{default: 1'b0};
        turnB = 1'b0; pendWe = 1'b0; pendAddr = '0;
        expWaddr = '0; expWdata = '0;
        repeat (2) @(posedge clk);

        // A alone
        step(0, 1, 7, 5, 0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        idle();
        // A and B together from reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 10, 1, 4, 20, 0, 0, 3, 4);
        step(0, 1, 3, 10, 1, 4, 20, 0, 0, 3, 4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        idle();
        // WAW stall on a reserved register
        step(0, 0, 0, 0, 0, 0, 0, 1, 18, 18, 0);
        step(0, 1, 18, 1, 0, 0, 0, 0, 0, 18, 0);
        step(0, 1, 18, 1, 1, 18, 13, 0, 0, 18, 0);
        step(0, 1, 18, 1, 0, 0, 0, 0, 0, 18, 0);
        idle();
        // double reservation, reserve $0
        step(0, 0, 0, 0, 0, 0, 0, 1, 19, 19, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 19, 19, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 19, 7, 0, 0, 19, 0);
        // write to $0 is dropped
        step(0, 1, 0, 99, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-stream
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        step(1, 0, 0, 0, 1, 5, 44, 0, 0, 5, 0);
        step(0, 0, 0, 0, 1, 5, 44, 0, 0, 5, 0);
        idle();

        for (int n = 0; n < 500; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            av = $urandom_range(0, 1);
            bv = $urandom_range(0, 1);
            rv = ($urandom_range(0, 2) == 0);
            aa = 5'($urandom_range(0, 7));
            ba = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            if (rv && bv && ra == ba) rv = 1'b0;
            step(r, av, aa, $urandom, bv, ba, $urandom, rv, ra,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        idle();
        idle();
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters:
  - requester A: ALU / single-cycle writeback.
  - requester B: multi-cycle unit (load, multiply).
- Keeps a 32-bit reservation scoreboard for B's outstanding destinations. Stalls A on write-after-write hazards and flags read hazards to the decode stage.
- Drives writeEnable, writeAddress and writeData of the register file from a registered output stage.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, register count (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- a_valid  in  1  A has a write pending.
- a_ready  out  1  A accepted this cycle when a_valid && a_ready.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  B has a write pending.
- b_ready  out  1  B accepted this cycle when b_valid && b_ready.
- b_addr  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- rsv_valid  in  1  B issue reserves a destination register.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ready  out  1  reservation accepted when rsv_valid && rsv_ready.
- rd_addr1  in  ADDR_W  decode read address 1.
- rd_addr2  in  ADDR_W  decode read address 2.
- rd_busy1  out  1  read 1 would return stale data.
- rd_busy2  out  1  read 2 would return stale data.
- rf_we  out  1  register file writeEnable.
- rf_waddr  out  ADDR_W  register file writeAddress.
- rf_wdata  out  DATA_W  register file writeData.
- busy_vec  out  NUM_REGS  scoreboard, bit i = register i reserved.

Behaviour:
- Clocking and reset: single clock domain. rst is sampled only at posedge clk. While rst is high:
  - all ready outputs are 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0.
  - prio=A.
- Reset mid-operation: all reservations and the pending output-stage write are discarded. Requesters must reissue.
- Arbitration, using internal 1-bit prio (A/B):
  - b_ready = !(a_valid && prio==A && !a_stall).
  - a_ready = !a_stall && !(b_valid && prio==B).
  - a_stall = busy[a_addr] && a_addr!=0, i.e. A is held off a B-reserved register (WAW).
  - If A is stalled and B is valid, B wins regardless of prio.
  - Ready outputs are combinational from the other requester's valid, never from their own valid.
  - At most one write is accepted per cycle.
  - After any accept, prio points to the other requester. With no accept, prio holds.
- Output stage:
  - On accept at edge N: rf_waddr and rf_wdata load the winner's addr/data, and rf_we = (addr != 0).
  - rf_we is high during cycle N+1; the register file commits at edge N+1. Accept-to-commit is 1 cycle.
  - With no accept, rf_we <= 0 and rf_waddr/rf_wdata hold their values.
  - Writes to $0 are accepted and dropped (rf_we stays 0).
- Scoreboard:
  - An accepted reservation sets busy[rsv_addr]. Reserving $0 is accepted and sets nothing.
  - rsv_ready = !busy[rsv_addr] using the registered busy value, no bypass. Re-reserving a busy register stalls, including in the same cycle its B write is accepted.
  - An accepted B write clears busy[b_addr]. Clearing an unreserved bit is harmless.
  - A set and a clear of different bits in the same cycle both take effect.
- Read hazard: rd_busyK = busy[rd_addrK] || (rf_we && rf_waddr==rd_addrK). The asynchronous read in the commit cycle still returns the old value. Both flags are forced to 0 when rd_addrK == 0.
- Width rules: addresses compare at full ADDR_W. Data passes through unmodified.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS.
  - REG_ZERO constant (5'd0).
  - requester enum {REQ_A, REQ_B} used for prio and grant.
- One sub-module, rr_arb2: a two-requester round-robin with a hold-off input for A (a_stall). It outputs the grants and owns the prio flop.
- Scoreboard, output stage and hazard compare stay in the top module.

Test Plan:
- Reset, then A writes $7=5 alone → a_ready=1; next cycle rf_we=1, rf_waddr=7, rf_wdata=5; following cycle rf_we=0.
- A ($3=10) and B ($4=20) both valid for 2 cycles from reset → A granted first, then B. rf sees $3 then $4 on consecutive cycles; prio ends at A.
- Reserve $18, then A writes $18=1 → a_ready=0 while busy_vec[18]=1. B writes $18=13 → busy clears. A is accepted the cycle after the B accept.
- Reserve $19 twice back-to-back → second rsv_ready=0. Reserve $0 → rsv_ready=1 and busy_vec unchanged.
- A writes $0=99 → a_ready=1 and rf_we stays 0. rd_addr1=0 → rd_busy1=0 throughout.
- Reserve $5, assert rst mid-stream with B valid → next cycle busy_vec=0, rf_we=0, readies=0. After rst drops, B is accepted normally.
